conv_out_serializer_8ch: RTL and testbench
==========================================

// Module: conv_out_serializer_8ch
// PURPOSE
//  Sink end of the 8-kernel conv3d output interface. Captures the 8 parallel kernel
//  results presented with each valid pixel, buffers them, and re-emits them as one
//  word per cycle (channel 0..7 order) on a valid/ready stream toward the next layer
//  or memory writer. Flags last channel / last pixel of a frame and frame errors.
// PARAMETERS
//  DATA_WIDTH  32  width of one kernel result word
//  NUM_KERNEL  8   parallel results per pixel (fixed 8 for port list; power of 2)
//  IMG_WIDTH   56  output feature-map width in pixels
//  IMG_HEIGHT  56  output feature-map height in pixels
//  FIFO_DEPTH  4   pixel entries buffered (power of 2, >=2)
// PORTS
//  clk          in   1    clock, all logic on rising edge
//  reset        in   1    synchronous, active-high reset
//  valid_in     in   1    pixel strobe from conv (valid_out_pixel)
//  done_in      in   1    end-of-frame strobe from conv (done_img)
//  data_in0..7  in   DATA_WIDTH each  kernel 0..7 results, sampled when valid_in=1
//  data_out     out  DATA_WIDTH  current serialized word
//  chan_out     out  3    kernel index of data_out
//  out_valid    out  1    data_out/chan_out/flags valid
//  out_ready    in   1    downstream accepts word when out_valid & out_ready
//  last_chan    out  1    data_out is channel NUM_KERNEL-1
//  last_pixel   out  1    data_out is final channel of final pixel of frame
//  done_out     out  1    1-cycle pulse after final word of frame handshakes
//  overflow     out  1    sticky: pixel dropped because buffer full
//  frame_err    out  1    sticky: done_in not coincident with pixel W*H-1
// BEHAVIOUR
//  - Reset: out_valid, done_out, overflow, frame_err, last_chan, last_pixel = 0;
//    data_out = 0, chan_out = 0; FIFO empty; all counters 0. Mid-frame reset
//    discards buffered pixels and restarts frame counting.
//  - Capture: on valid_in, the 8 words form one NUM_KERNEL*DATA_WIDTH entry pushed to
//    the FIFO. Push when not full, or when full AND the head entry is popped that same
//    cycle. Otherwise drop the pixel, set overflow (cleared only by reset), and do not
//    advance the input pixel counter.
//  - Input pixel counter in_cnt counts accepted pixels 0..W*H-1, wraps to 0.
//    done_in must arrive in the same cycle as valid_in with in_cnt==W*H-1. A done_in
//    in any other cycle sets frame_err (sticky) and does not alter counters.
//  - Emit: out_valid = FIFO not empty. data_out = head entry word[chan], where chan
//    is the output channel counter. Show-ahead: word 0 of a pixel pushed at edge N is
//    valid at edge N+1 (1-cycle latency), and full throughput is 1 word/cycle.
//  - On out_valid & out_ready: chan increments; at chan==NUM_KERNEL-1, chan -> 0,
//    the head entry is popped, and out_pix increments (wraps at W*H-1 -> 0).
//  - out_valid low: chan holds and data_out = 0. While out_ready is low, data_out,
//    chan_out and the flags hold stable.
//  - last_chan = out_valid & (chan==NUM_KERNEL-1);
//    last_pixel = last_chan & (out_pix==W*H-1).
//  - done_out: registered pulse in the cycle after the last_pixel word handshakes.
//  - Throughput note: conv must not present a pixel more often than every NUM_KERNEL
//    cycles on average; bursts up to FIFO_DEPTH are absorbed.
//  - Widths: pixel counters $clog2(W*H) bits; FIFO pointers $clog2(FIFO_DEPTH)+1.
// STRUCTURE
//  - Shared package/header: CONV_NUM_KERNEL=8, CHAN_W=$clog2(8), and a pixel-count
//    width function, reused by the conv and pooling layers.
//  - Sub-module: sync_fifo_wide (show-ahead synchronous FIFO,
//    WIDTH=NUM_KERNEL*DATA_WIDTH, DEPTH=FIFO_DEPTH, full/empty, simultaneous push/pop).
//  - Top holds the capture concat, the channel/pixel counters, the output mux and the
//    flags.
// TESTING
//  1. One pixel, data_inK=32'h1000+K, out_ready=1 -> 8 words 0x1000..0x1007, chan 0..7,
//     last_chan only on word 7, out_valid in cycles N+1..N+8.
//  2. out_ready toggles 1010..., 3 pixels -> 24 words, in order, none lost or
//     duplicated, outputs stable during stalls.
//  3. FIFO_DEPTH=4, out_ready=0, 6 back-to-back pixels -> 4 stored, overflow=1 after
//     the 5th, then release -> exactly 32 words.
//  4. W=H=2, 4 pixels, done_in with 4th -> last_pixel on word 31 only, done_out
//     1 cycle later, frame_err=0.
//  5. done_in with 2nd pixel of a 4-pixel frame -> frame_err=1, counters unaffected.
//  6. reset asserted after 3 words of a pixel -> all outputs 0 next cycle; next pixel
//     starts at chan 0 with out_pix=0.

Source files
------------

// File: rtl/conv_out_serializer_8ch_pkg.sv
// Shared conv-layer constants and helpers, reused by the conv and pooling layers.
package conv_out_serializer_8ch_pkg;

  localparam int CONV_NUM_KERNEL = 8;
  localparam int CHAN_W          = $clog2(CONV_NUM_KERNEL);

  // A 1-pixel frame would otherwise give a zero-width counter.
  function automatic int pix_cnt_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/conv_out_serializer_8ch_sync_fifo_wide.sv
// Show-ahead synchronous FIFO: the head entry is readable in the cycle after its push.
module sync_fifo_wide #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // The extra pointer bit separates full from empty when the indices match.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/conv_out_serializer_8ch.sv
// Captures the 8 kernel results of each conv output pixel and replays them
// one word per cycle on a valid/ready stream, flagging frame boundaries and errors.
module conv_out_serializer_8ch
  import conv_out_serializer_8ch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_KERNEL = CONV_NUM_KERNEL,
  parameter int IMG_WIDTH  = 56,
  parameter int IMG_HEIGHT = 56,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  done_in,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic [DATA_WIDTH-1:0] data_in4,
  input  logic [DATA_WIDTH-1:0] data_in5,
  input  logic [DATA_WIDTH-1:0] data_in6,
  input  logic [DATA_WIDTH-1:0] data_in7,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CHAN_W-1:0]     chan_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  last_chan,
  output logic                  last_pixel,
  output logic                  done_out,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int                ENTRY_W   = NUM_KERNEL * DATA_WIDTH;
  localparam int                PIX_W     = pix_cnt_w(IMG_WIDTH, IMG_HEIGHT);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_KERNEL - 1);

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               handshake;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;
  logic [CHAN_W-1:0]  chan;
  logic [PIX_W-1:0]   in_cnt;
  logic [PIX_W-1:0]   out_pix;

  // Kernel k lands in word k of the entry so the output mux indexes by channel.
  assign entry = {data_in7, data_in6, data_in5, data_in4,
                  data_in3, data_in2, data_in1, data_in0};

  assign out_valid = ~fifo_empty;
  assign handshake = out_valid & out_ready;
  assign pop       = handshake & (chan == LAST_CHAN);
  assign push      = valid_in & (~fifo_full | pop);

  sync_fifo_wide #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign data_out   = out_valid ? head[chan*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign chan_out   = chan;
  assign last_chan  = out_valid & (chan == LAST_CHAN);
  assign last_pixel = last_chan & (out_pix == LAST_PIX);

  // A dropped pixel never advances in_cnt, so frame position tracks stored pixels only.
  always_ff @(posedge clk) begin
    if (reset) begin
      chan      <= '0;
      in_cnt    <= '0;
      out_pix   <= '0;
      done_out  <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (handshake) chan <= pop ? '0 : chan + 1'b1;
      if (pop)       out_pix <= (out_pix == LAST_PIX) ? '0 : out_pix + 1'b1;
      if (push)      in_cnt  <= (in_cnt == LAST_PIX) ? '0 : in_cnt + 1'b1;
      if (valid_in && !push) overflow <= 1'b1;
      if (done_in && !(valid_in && (in_cnt == LAST_PIX))) frame_err <= 1'b1;
      done_out <= handshake & last_pixel;
    end
  end

endmodule

// File: tb/tb_conv_out_serializer_8ch.sv
// Self-checking bench: hand-built vector table, directed frame sequences and a
// randomized phase, all checked against a queue-based reference model.
module tb_conv_out_serializer_8ch;

  localparam int DW    = 32;
  localparam int NK    = 8;
  localparam int IW    = 2;
  localparam int IH    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = IW * IH;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic          done_in;
  logic          out_ready;
  logic [DW-1:0] data_in [NK];
  logic [DW-1:0] data_out;
  logic [2:0]    chan_out;
  logic          out_valid;
  logic          last_chan;
  logic          last_pixel;
  logic          done_out;
  logic          overflow;
  logic          frame_err;

  always #5 clk = ~clk;

  conv_out_serializer_8ch #(
    .DATA_WIDTH (DW),
    .NUM_KERNEL (NK),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .done_in    (done_in),
    .data_in0   (data_in[0]),
    .data_in1   (data_in[1]),
    .data_in2   (data_in[2]),
    .data_in3   (data_in[3]),
    .data_in4   (data_in[4]),
    .data_in5   (data_in[5]),
    .data_in6   (data_in[6]),
    .data_in7   (data_in[7]),
    .data_out   (data_out),
    .chan_out   (chan_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .last_chan  (last_chan),
    .last_pixel (last_pixel),
    .done_out   (done_out),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  // Reference model: a queue of whole pixels plus the reader's position in the frame.
  logic [NK*DW-1:0] mq [$];
  int m_chan, m_out_pix, m_in_cnt;
  bit m_overflow, m_frame_err, m_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_words  = 0;

  typedef struct {
    bit          v;
    bit          r;
    bit          ev;
    logic [2:0]  ec;
    logic [31:0] ed;
    bit          elc;
  } vec_t;

  vec_t tbl [10];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_chan      = 0;
    m_out_pix   = 0;
    m_in_cnt    = 0;
    m_overflow  = 0;
    m_frame_err = 0;
    m_done      = 0;
  endtask

  task automatic checkZero(input string tag);
    cmp({tag, "_out_valid"},  out_valid,  0);
    cmp({tag, "_data_out"},   data_out,   0);
    cmp({tag, "_chan_out"},   chan_out,   0);
    cmp({tag, "_last_chan"},  last_chan,  0);
    cmp({tag, "_last_pixel"}, last_pixel, 0);
    cmp({tag, "_done_out"},   done_out,   0);
    cmp({tag, "_overflow"},   overflow,   0);
    cmp({tag, "_frame_err"},  frame_err,  0);
  endtask

  task automatic checkOutput();
    bit               ev, elc;
    logic [DW-1:0]    ed;
    logic [NK*DW-1:0] hd;
    ev  = mq.size() > 0;
    ed  = '0;
    if (ev) begin
      hd = mq[0];
      ed = hd[m_chan*DW +: DW];
    end
    elc = ev && (m_chan == NK - 1);
    cmp("out_valid",  out_valid,  ev);
    cmp("data_out",   data_out,   ed);
    cmp("chan_out",   chan_out,   32'(m_chan));
    cmp("last_chan",  last_chan,  elc);
    cmp("last_pixel", last_pixel, elc && (m_out_pix == FRAME - 1));
    cmp("done_out",   done_out,   m_done);
    cmp("overflow",   overflow,   m_overflow);
    cmp("frame_err",  frame_err,  m_frame_err);
  endtask

  // Drive one cycle: check current outputs, advance the model, then clock the DUT.
  task automatic applyStimulus(input bit v, input bit d, input bit r);
    bit hs, pop, acc, lp;
    logic [NK*DW-1:0] ent;
    valid_in  = v;
    done_in   = d;
    out_ready = r;
    checkOutput();
    for (int k = 0; k < NK; k++) ent[k*DW +: DW] = data_in[k];
    hs  = (mq.size() > 0) && r;
    pop = hs && (m_chan == NK - 1);
    lp  = pop && (m_out_pix == FRAME - 1);
    acc = v && ((mq.size() < DEPTH) || pop);
    if (d && !(v && (m_in_cnt == FRAME - 1))) m_frame_err = 1;
    if (hs) begin
      n_words++;
      if (pop) begin
        mq.delete(0);
        m_chan    = 0;
        m_out_pix = (m_out_pix + 1) % FRAME;
      end else begin
        m_chan++;
      end
    end
    if (acc) begin
      mq.push_back(ent);
      m_in_cnt = (m_in_cnt + 1) % FRAME;
    end else if (v) begin
      m_overflow = 1;
    end
    m_done = lp;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input string tag);
    reset     = 1'b1;
    valid_in  = 1'b0;
    done_in   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    checkZero(tag);
    reset = 1'b0;
  endtask

  task automatic randData();
    for (int k = 0; k < NK; k++) data_in[k] = $urandom();
  endtask

  // One frame of FRAME pixels spaced NK cycles apart with the sink always ready.
  task automatic runFrame(input int done_idx, output int lp_idx, output int lp_cnt);
    int wc;
    bit lp_now;
    wc     = 0;
    lp_idx = -1;
    lp_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      randData();
      lp_now = out_valid && last_pixel;
      if (out_valid) begin
        if (last_pixel) begin
          lp_idx = wc;
          lp_cnt++;
        end
        wc++;
      end
      applyStimulus((c % NK == 0) && (c < FRAME * NK), c == done_idx * NK, 1'b1);
      if (lp_now) cmp("done_out_pulse", done_out, 1);
    end
  endtask

  initial begin
    int w0, lp_idx, lp_cnt;
    reset     = 1'b1;
    valid_in  = 1'b0;
    done_in   = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < NK; k++) data_in[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkZero("reset");
    reset = 1'b0;

    // Test 1: single pixel, words 0x1000..0x1007 in the 8 cycles after capture.
    tbl[0].v = 1; tbl[0].r = 1; tbl[0].ev = 0; tbl[0].ec = 0; tbl[0].ed = 0; tbl[0].elc = 0;
    for (int k = 1; k <= 8; k++) begin
      tbl[k].v   = 0;
      tbl[k].r   = 1;
      tbl[k].ev  = 1;
      tbl[k].ec  = 3'(k - 1);
      tbl[k].ed  = 32'h1000 + 32'(k - 1);
      tbl[k].elc = (k == 8);
    end
    tbl[9].v = 0; tbl[9].r = 1; tbl[9].ev = 0; tbl[9].ec = 0; tbl[9].ed = 0; tbl[9].elc = 0;
    for (int k = 0; k < NK; k++) data_in[k] = 32'h1000 + 32'(k);
    for (int i = 0; i < 10; i++) begin
      cmp($sformatf("t1_valid[%0d]", i), out_valid, tbl[i].ev);
      cmp($sformatf("t1_chan[%0d]", i),  chan_out,  tbl[i].ec);
      cmp($sformatf("t1_data[%0d]", i),  data_out,  tbl[i].ed);
      cmp($sformatf("t1_lchan[%0d]", i), last_chan, tbl[i].elc);
      applyStimulus(tbl[i].v, 1'b0, tbl[i].r);
    end

    // Test 2: three pixels while out_ready toggles 1,0,1,0...
    w0 = n_words;
    for (int c = 0; c < 60; c++) begin
      randData();
      applyStimulus(c < 3, 1'b0, (c % 2) == 0);
    end
    cmp("t2_word_count", n_words - w0, 24);

    // Test 3: sink stalled, six back-to-back pixels, then release.
    w0 = n_words;
    for (int c = 0; c < 6; c++) begin
      randData();
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (c == 3) cmp("t3_no_overflow_after_4", overflow, 0);
      if (c == 4) cmp("t3_overflow_after_5", overflow, 1);
    end
    for (int c = 0; c < 40; c++) applyStimulus(1'b0, 1'b0, 1'b1);
    cmp("t3_word_count", n_words - w0, 32);

    // Test 4: well-formed frame, done_in with the 4th pixel.
    applyReset("t4_reset");
    runFrame(3, lp_idx, lp_cnt);
    cmp("t4_last_pixel_word", lp_idx, 31);
    cmp("t4_last_pixel_count", lp_cnt, 1);
    cmp("t4_frame_err", frame_err, 0);

    // Test 5: done_in on the 2nd pixel flags an error but leaves framing intact.
    runFrame(1, lp_idx, lp_cnt);
    cmp("t5_frame_err", frame_err, 1);
    cmp("t5_last_pixel_word", lp_idx, 31);
    cmp("t5_last_pixel_count", lp_cnt, 1);

    // Test 6: reset three words into a pixel, then a clean frame from scratch.
    applyReset("t6_pre_reset");
    randData();
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b1);
    cmp("t6_chan_before_reset", chan_out, 3);
    applyReset("t6_mid_reset");
    runFrame(3, lp_idx, lp_cnt);
    cmp("t6_last_pixel_word", lp_idx, 31);
    cmp("t6_frame_err", frame_err, 0);

    // Randomized traffic against the model.
    applyReset("rand_reset");
    for (int c = 0; c < 1500; c++) begin
      bit v, d, r;
      randData();
      v = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 3) != 0);
      if (v && (m_in_cnt == FRAME - 1)) d = ($urandom_range(0, 7) != 0);
      else                              d = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 499) == 0) applyReset("rand_mid_reset");
      else                             applyStimulus(v, d, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
